scratch_ram: RTL and testbench

- 32-entry x 8-bit scratch RAM for the RAT CPU, used as the stack and scratch data store.
- Combinational (asynchronous) read and synchronous write on the rising edge of CLK.
- Asynchronous active-low reset clears every entry to 0.
- Sits beside the register file; address comes from the CPU's SCR address mux, data from the register file / immediate mux.

---
 rtl/rat_pkg.sv | 11 +
 rtl/scratch_ram.sv | 40 ++++
 tb/tb_scratch_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
// Shared RAT CPU datapath widths and types used by the scratch RAM, register file and datapath.
package rat_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int SCR_DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] scr_addr_t;

endpackage

// File: rtl/scratch_ram.sv
// 32 x 8 scratch RAM (stack / scratch store): combinational read, synchronous write,
// asynchronous active-low clear of every entry.
module scratch_ram
  import rat_pkg::*;
#(
  parameter int DATA_W = rat_pkg::DATA_W,
  parameter int ADDR_W = rat_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [ADDR_W-1:0] SCR_ADDR,
  input  logic              SCR_WE,
  output logic [DATA_W-1:0] DATA_OUT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  wr_sel;

  // Every entry is its own register so the whole array can clear asynchronously.
  // An X/Z write enable makes the if-condition false, so it never writes in simulation.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wr_sel[gi] = (SCR_ADDR == ADDR_W'(gi));

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          mem_q[gi] <= '0;
        end else if ((SCR_WE == 1'b1) && wr_sel[gi]) begin
          mem_q[gi] <= DATA_IN;
        end
      end
    end
  endgenerate

  assign DATA_OUT = mem_q[SCR_ADDR];

endmodule

// File: tb/tb_scratch_ram.sv
// Randomised and directed bench for scratch_ram; expected read data comes from a plain array model
// and is checked by a separate monitor through a scoreboard queue.
module tb_scratch_ram;
  import rat_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  DATA_IN;
  logic [4:0]  SCR_ADDR;
  logic        SCR_WE;
  logic [7:0]  DATA_OUT;

  scratch_ram dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DATA_IN  (DATA_IN),
    .SCR_ADDR (SCR_ADDR),
    .SCR_WE   (SCR_WE),
    .DATA_OUT (DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string    name;
    int       addr;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  event       chk_ev;
  int         vectors = 0;
  int         miscompares = 0;
  int         model[32];
  int         cur_addr = 0;
  int         cur_data = 0;
  int         cur_we = 0;

  // Monitor: pops each expectation the stimulus posted and compares the live read port.
  initial begin
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        vectors++;
        if (DATA_OUT !== e.exp) begin
          miscompares++;
          $display("FAIL %s addr=%0d got=%02h exp=%02h", e.name, e.addr, DATA_OUT, e.exp);
        end else begin
          $display("ok   %s addr=%0d data=%02h", e.name, e.addr, DATA_OUT);
        end
      end
    end
  end

  task automatic drive(input int we, input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av = a;
    dv = d;
    cur_we = we;
    cur_addr = a;
    cur_data = d;
    SCR_WE = (we != 0);
    SCR_ADDR = av[4:0];
    DATA_IN = dv[7:0];
    #1;
  endtask

  task automatic set_addr(input int a);
    logic [31:0] av;
    av = a;
    cur_addr = a;
    SCR_ADDR = av[4:0];
  endtask

  // Checks right away (same time step as any address change), then steps 1 time unit.
  task automatic check(input string name);
    exp_t e;
    #0;
    e.name = name;
    e.addr = cur_addr % 32;
    e.exp = 8'(model[cur_addr % 32]);
    sb_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    if (RST_N === 1'b1 && cur_we != 0) model[cur_addr % 32] = cur_data % 256;
    #2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 0;
    RST_N = 1'b0;
    drive(0, 0, 0);
    clear_model();
    clk_edge();
    clk_edge();
    check("in_reset");
    RST_N = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      check("post_reset_sweep");
    end

    drive(0, 4, 8'hAA);
    for (int k = 0; k < 3; k++) clk_edge();
    check("no_write_we0");
    set_addr(7);
    check("addr_change_same_delta");

    drive(1, 5, 255);
    check("before_write_edge");
    clk_edge();
    check("after_write_edge");
    drive(0, 5, 0);
    clk_edge();
    check("we0_keeps_value");
    set_addr(3);
    check("other_entry_zero");

    for (int i = 0; i < 32; i++) begin
      drive(1, i, i * 7 + 1);
      clk_edge();
    end
    drive(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_addr(i);
      check("fill_readback");
    end

    drive(1, 100, 8'h5A);
    clk_edge();
    drive(0, 4, 0);
    check("trunc_100_to_4");
    drive(1, 255, 8'hC3);
    clk_edge();
    drive(0, 31, 0);
    check("trunc_255_to_31");

    for (int n = 0; n < 200; n++) begin
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
      check("rand_pre_edge");
      clk_edge();
      check("rand_post_edge");
      set_addr(int'($urandom_range(0, 31)));
      check("rand_read");
    end

    for (int i = 0; i < 32; i++) begin
      drive(1, i, 255 - i);
      clk_edge();
    end
    drive(1, 9, 8'h11);
    check("filled_before_reset");
    RST_N = 1'b0;
    clear_model();
    #1;
    check("async_reset_no_edge");
    clk_edge();
    check("edge_in_reset_no_write");
    drive(0, 0, 0);
    RST_N = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      check("after_reset_release");
    end

    #5;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
